// File: rtl/serial_receiver.sv
// -----------------------------------------------------------------------------
// serial_receiver
//   UART receiver, 8N1, LSB first. It is the receive-side partner of the serial
//   transmitter and uses the same bit timing. The asynchronous RX line is
//   synchronised, oversampled with CLK, and each bit is sampled at mid-period.
//   The last correctly framed byte is held in a one-deep register with a
//   valid/read handshake. Framing errors and overruns are flagged.
//
// Parameters
//   CLOCKS_WAIT     bit-timing constant; bit period BIT = CLOCKS_WAIT + 2 clocks
//
// Ports
//   CLK             system clock
//   RESET           synchronous, active-high reset
//   IN_SERIAL_RX    asynchronous serial line, idle high
//   IN_READ         one-cycle pulse; consumes the held byte
//   OUT_DATA        last correctly framed byte
//   OUT_DATA_VALID  held byte not yet consumed
//   OUT_OVERRUN     sticky: a byte completed while OUT_DATA_VALID was set
//   OUT_FRAME_ERROR one-cycle pulse: stop bit sampled low
//   OUT_STATUS_BUSY high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module serial_receiver #(
  parameter int CLOCKS_WAIT = 434
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IN_SERIAL_RX,
  input  logic       IN_READ,
  output logic [7:0] OUT_DATA,
  output logic       OUT_DATA_VALID,
  output logic       OUT_OVERRUN,
  output logic       OUT_FRAME_ERROR,
  output logic       OUT_STATUS_BUSY
);

  localparam int BIT  = CLOCKS_WAIT + 2;
  localparam int HALF = BIT / 2;

  // Terminal counts: a phase lasting N clocks ends when the counter reads N-1.
  localparam logic [11:0] BIT_LAST  = 12'(BIT - 1);
  localparam logic [11:0] HALF_LAST = 12'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } stateType;

  stateType    state;
  logic        rxMeta;
  logic        rxSync;
  logic [11:0] cycleCount;
  logic [2:0]  bitIndex;
  logic [7:0]  shiftReg;

  // Two-flop synchroniser. Both stages reset high so that a reset never looks
  // like a start bit.
  // NOTE: clocked state is always written with non-blocking assignments so that
  // every flop samples the values from before the edge, independent of
  // statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= IN_SERIAL_RX;
      rxSync <= rxMeta;
    end
  end

  // Receive FSM, holding register and status flags. The cycle counter is
  // cleared on every state change so each phase starts counting from zero.
  // NOTE: the reset is synchronous, so RESET is only seen inside the clocked
  // branch and a reset mid-frame simply drops the partial byte.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state           <= IDLE;
      cycleCount      <= '0;
      bitIndex        <= '0;
      shiftReg        <= '0;
      OUT_DATA        <= '0;
      OUT_DATA_VALID  <= 1'b0;
      OUT_OVERRUN     <= 1'b0;
      OUT_FRAME_ERROR <= 1'b0;
    end else begin
      OUT_FRAME_ERROR <= 1'b0;

      // Consuming the held byte. A byte completing in the same cycle below
      // overrides OUT_DATA_VALID, while OUT_OVERRUN stays cleared.
      if (IN_READ && OUT_DATA_VALID) begin
        OUT_DATA_VALID <= 1'b0;
        OUT_OVERRUN    <= 1'b0;
      end

      case (state)
        IDLE: begin
          cycleCount <= '0;
          if (!rxSync) state <= START;
        end

        START: begin
          if (cycleCount == HALF_LAST) begin
            cycleCount <= '0;
            if (rxSync) begin
              state <= IDLE;             // false start, nothing reported
            end else begin
              state    <= DATA;
              bitIndex <= '0;
            end
          end else begin
            cycleCount <= cycleCount + 12'd1;
          end
        end

        DATA: begin
          if (cycleCount == BIT_LAST) begin
            cycleCount <= '0;
            shiftReg   <= {rxSync, shiftReg[7:1]};  // LSB arrives first
            if (bitIndex == 3'd7) state <= STOP;
            else                  bitIndex <= bitIndex + 3'd1;
          end else begin
            cycleCount <= cycleCount + 12'd1;
          end
        end

        STOP: begin
          if (cycleCount == BIT_LAST) begin
            cycleCount <= '0;
            if (rxSync) begin
              // New byte overwrites an unread one; that is what OUT_OVERRUN flags.
              OUT_DATA       <= shiftReg;
              OUT_DATA_VALID <= 1'b1;
              if (OUT_DATA_VALID && !IN_READ) OUT_OVERRUN <= 1'b1;
              state <= IDLE;
            end else begin
              OUT_FRAME_ERROR <= 1'b1;
              state           <= WAIT_HIGH;
            end
          end else begin
            cycleCount <= cycleCount + 12'd1;
          end
        end

        WAIT_HIGH: begin
          // A held-low break must end before a new start bit is accepted.
          cycleCount <= '0;
          if (rxSync) state <= IDLE;
        end

        default: begin
          cycleCount <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign OUT_STATUS_BUSY = (state != IDLE);

endmodule

// File: tb/tb_serial_receiver.sv
`timescale 1ns/1ps
module tb_serial_receiver;

  localparam int CLOCKS_WAIT = 14;
  localparam int BIT         = CLOCKS_WAIT + 2;
  localparam int HALF        = BIT / 2;
  // Edges from the first low-driven cycle of a start bit to the VALID update.
  localparam int LATENCY     = 2 + HALF + 9 * BIT;
  // Stop-bit cycle whose edge is the byte completion edge.
  localparam int READ_AT_COMPLETION = LATENCY - 9 * BIT;
  localparam int N           = 6000;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       IN_SERIAL_RX = 1'b1;
  logic       IN_READ = 1'b0;
  logic [7:0] OUT_DATA;
  logic       OUT_DATA_VALID;
  logic       OUT_OVERRUN;
  logic       OUT_FRAME_ERROR;
  logic       OUT_STATUS_BUSY;

  serial_receiver #(.CLOCKS_WAIT(CLOCKS_WAIT)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .IN_SERIAL_RX    (IN_SERIAL_RX),
    .IN_READ         (IN_READ),
    .OUT_DATA        (OUT_DATA),
    .OUT_DATA_VALID  (OUT_DATA_VALID),
    .OUT_OVERRUN     (OUT_OVERRUN),
    .OUT_FRAME_ERROR (OUT_FRAME_ERROR),
    .OUT_STATUS_BUSY (OUT_STATUS_BUSY)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Number of rising edges so far.
  int cycleNum = 0;
  always @(posedge CLK) cycleNum <= cycleNum + 1;

  // Output monitor, sampled on the falling edge.
  int   ferrRises = 0;
  int   ferrHigh = 0;
  int   busyCycles = 0;
  int   validRiseCycle = 0;
  logic prevFerr = 1'b0;
  logic prevValid = 1'b0;
  always @(negedge CLK) begin
    if (OUT_FRAME_ERROR) ferrHigh = ferrHigh + 1;
    if (OUT_FRAME_ERROR && !prevFerr) ferrRises = ferrRises + 1;
    if (OUT_DATA_VALID && !prevValid) validRiseCycle = cycleNum;
    if (OUT_STATUS_BUSY) busyCycles = busyCycles + 1;
    prevFerr  = OUT_FRAME_ERROR;
    prevValid = OUT_DATA_VALID;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Hold the line at v for n clock cycles (one new value per falling edge).
  task automatic driveBit(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      IN_SERIAL_RX = v;
    end
  endtask

  // One 8N1 frame. readAt >= 0 pulses IN_READ during that stop-bit cycle
  // (must be below BIT-1 so the pulse is dropped inside the frame).
  task automatic sendFrame(input logic [7:0] b, input logic stopBit, input int readAt,
                           output int startCycle);
    @(negedge CLK);
    IN_SERIAL_RX = 1'b0;
    startCycle = cycleNum + 1;
    driveBit(1'b0, BIT - 1);
    for (int k = 0; k < 8; k++) driveBit(b[k], BIT);
    for (int i = 0; i < BIT; i++) begin
      @(negedge CLK);
      IN_SERIAL_RX = stopBit;
      IN_READ = (i == readAt);
    end
  endtask

  task automatic pulseRead();
    @(negedge CLK);
    IN_READ = 1'b1;
    @(negedge CLK);
    IN_READ = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Random-phase reference model: the line waveform is built up front, then
  // decoded by the UART rules (falling edge, mid-bit samples) into a list of
  // completion events, then the holding-register handshake is applied per edge.
  // lineArr[i] is the line value seen at clock edge i; the synchroniser makes
  // the receiver act on it two edges later.
  // ---------------------------------------------------------------------------
  logic        lineArr [N];
  logic        rdArr   [N];
  logic [1:0]  evKind  [N];   // 0 none, 1 good byte, 2 framing error
  logic [7:0]  evByte  [N];
  logic [10:0] expVec  [N];   // {valid, overrun, frame_error, data}

  task automatic buildRandom();
    int idx, len, hold, pos, f, s, j;
    logic [7:0] b;
    logic stopBad;
    bit done;
    logic valid, ovr, ferr;
    logic [7:0] data;

    for (int i = 0; i < N; i++) begin
      lineArr[i] = 1'b1;
      rdArr[i]   = ($urandom_range(0, 24) == 0);
      evKind[i]  = 2'd0;
      evByte[i]  = 8'h00;
    end

    idx = 20;
    while (idx < N - 400) begin
      if ($urandom_range(0, 9) == 0) begin
        len = $urandom_range(1, 7);
        for (int k = 0; k < len; k++) lineArr[idx + k] = 1'b0;
        idx = idx + len + 12;
      end else begin
        b = 8'($urandom);
        stopBad = ($urandom_range(0, 6) == 0);
        for (int c = 0; c < BIT; c++) lineArr[idx + c] = 1'b0;
        for (int k = 0; k < 8; k++)
          for (int c = 0; c < BIT; c++) lineArr[idx + (k + 1) * BIT + c] = b[k];
        for (int c = 0; c < BIT; c++) lineArr[idx + 9 * BIT + c] = !stopBad;
        idx = idx + 10 * BIT;
        if (stopBad) begin
          hold = $urandom_range(0, 40);
          for (int c = 0; c < hold; c++) lineArr[idx + c] = 1'b0;
          idx = idx + hold + $urandom_range(1, 10);
        end else if ($urandom_range(0, 2) != 0) begin
          idx = idx + $urandom_range(1, 25);
        end
      end
    end

    // Decode the waveform. pos is the first line index an idle receiver looks at.
    pos = 0;
    done = 1'b0;
    while (!done) begin
      f = pos;
      while (f < N && lineArr[f]) f++;
      if (f + HALF + 9 * BIT + 2 >= N) begin
        done = 1'b1;
      end else if (lineArr[f + HALF]) begin
        pos = f + HALF + 1;                    // start bit not low at its middle
      end else begin
        for (int k = 0; k < 8; k++) b[k] = lineArr[f + HALF + (k + 1) * BIT];
        s = f + HALF + 9 * BIT;                // middle of the stop bit
        if (lineArr[s]) begin
          evKind[s + 2] = 2'd1;
          evByte[s + 2] = b;
          pos = s + 1;
        end else begin
          evKind[s + 2] = 2'd2;
          j = s + 1;
          while (j < N && !lineArr[j]) j++;
          pos = j + 1;
          if (j >= N) done = 1'b1;
        end
      end
    end

    valid = 1'b0;
    ovr   = 1'b0;
    data  = 8'h00;
    for (int i = 0; i < N; i++) begin
      ferr = (evKind[i] == 2'd2);
      if (evKind[i] == 2'd1) begin
        data = evByte[i];
        if (valid && !rdArr[i]) ovr = 1'b1;
        else if (valid && rdArr[i]) ovr = 1'b0;
        valid = 1'b1;
      end else if (rdArr[i] && valid) begin
        valid = 1'b0;
        ovr   = 1'b0;
      end
      expVec[i] = {valid, ovr, ferr, data};
    end
  endtask

  typedef struct {
    logic [7:0] txByte;
    logic       stopBit;
    logic       readAfter;
    logic [7:0] expData;
    logic       expValid;
    logic       expOverrun;
    int         expFerr;
  } frameVec;

  frameVec vecs[6];

  initial begin
    int startCycle, f0, h0, b0;
    logic prevExpValid;
    frameVec fr;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1};
    vecs[4] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 0};
    vecs[5] = '{8'h01, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1};

    // Reset, then idle line.
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    driveBit(1'b1, 100);
    check("reset outputs", {OUT_DATA, OUT_DATA_VALID, OUT_OVERRUN, OUT_FRAME_ERROR, OUT_STATUS_BUSY}, 32'h0);

    // Table-driven frames.
    prevExpValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fr = vecs[i];
      f0 = ferrRises;
      h0 = ferrHigh;
      sendFrame(fr.txByte, fr.stopBit, -1, startCycle);
      driveBit(1'b1, 20);
      check($sformatf("tbl%0d data", i), OUT_DATA, fr.expData);
      check($sformatf("tbl%0d valid", i), OUT_DATA_VALID, fr.expValid);
      check($sformatf("tbl%0d overrun", i), OUT_OVERRUN, fr.expOverrun);
      check($sformatf("tbl%0d ferr pulses", i), ferrRises - f0, fr.expFerr);
      check($sformatf("tbl%0d ferr cycles", i), ferrHigh - h0, fr.expFerr);
      if (fr.expValid && !prevExpValid)
        check($sformatf("tbl%0d latency", i), validRiseCycle, startCycle + LATENCY);
      prevExpValid = fr.expValid;
      if (fr.readAfter) begin
        pulseRead();
        check($sformatf("tbl%0d read valid", i), OUT_DATA_VALID, 1'b0);
        check($sformatf("tbl%0d read overrun", i), OUT_OVERRUN, 1'b0);
        prevExpValid = 1'b0;
      end
    end

    // Short low glitch: START for exactly HALF cycles, then back to idle.
    b0 = busyCycles;
    f0 = ferrRises;
    driveBit(1'b0, 5);
    driveBit(1'b1, 20);
    check("glitch busy cycles", busyCycles - b0, HALF);
    check("glitch valid", OUT_DATA_VALID, 1'b0);
    check("glitch ferr", ferrRises - f0, 0);

    // Bad stop bit followed by a long break, then recovery.
    f0 = ferrRises;
    h0 = ferrHigh;
    sendFrame(8'h3C, 1'b0, -1, startCycle);
    driveBit(1'b0, 200);
    check("break ferr pulses", ferrRises - f0, 1);
    check("break ferr cycles", ferrHigh - h0, 1);
    check("break valid", OUT_DATA_VALID, 1'b0);
    check("break busy", OUT_STATUS_BUSY, 1'b1);
    driveBit(1'b1, 20);
    check("break released busy", OUT_STATUS_BUSY, 1'b0);
    sendFrame(8'h81, 1'b1, -1, startCycle);
    driveBit(1'b1, 20);
    check("after break data", OUT_DATA, 8'h81);
    check("after break valid", OUT_DATA_VALID, 1'b1);
    pulseRead();

    // Back-to-back frames, no read in between.
    sendFrame(8'h11, 1'b1, -1, startCycle);
    sendFrame(8'h22, 1'b1, -1, startCycle);
    driveBit(1'b1, 10);
    check("b2b data", OUT_DATA, 8'h22);
    check("b2b valid", OUT_DATA_VALID, 1'b1);
    check("b2b overrun", OUT_OVERRUN, 1'b1);

    // Read on the exact completion edge: new byte held, overrun cleared.
    sendFrame(8'h33, 1'b1, READ_AT_COMPLETION, startCycle);
    driveBit(1'b1, 10);
    check("same-cycle data", OUT_DATA, 8'h33);
    check("same-cycle valid", OUT_DATA_VALID, 1'b1);
    check("same-cycle overrun", OUT_OVERRUN, 1'b0);
    pulseRead();
    check("read clears valid", OUT_DATA_VALID, 1'b0);

    // Read with nothing held does nothing.
    pulseRead();
    check("idle read valid", OUT_DATA_VALID, 1'b0);
    check("idle read overrun", OUT_OVERRUN, 1'b0);

    // Reset during bit 4 of 0x55 with a byte already held.
    sendFrame(8'h81, 1'b1, -1, startCycle);
    driveBit(1'b1, 10);
    f0 = ferrRises;
    @(negedge CLK);
    IN_SERIAL_RX = 1'b0;
    driveBit(1'b0, BIT - 1);
    for (int k = 0; k < 4; k++) driveBit(k[0] ? 1'b0 : 1'b1, BIT);
    driveBit(1'b1, 6);
    check("mid-frame busy", OUT_STATUS_BUSY, 1'b1);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("mid-frame reset", {OUT_DATA, OUT_DATA_VALID, OUT_OVERRUN, OUT_FRAME_ERROR, OUT_STATUS_BUSY}, 32'h0);
    driveBit(1'b1, 60);
    check("post-reset idle", {OUT_DATA, OUT_DATA_VALID, OUT_OVERRUN, OUT_STATUS_BUSY}, 32'h0);
    check("post-reset ferr", ferrRises - f0, 0);
    sendFrame(8'h55, 1'b1, -1, startCycle);
    driveBit(1'b1, 20);
    check("post-reset 0x55 data", OUT_DATA, 8'h55);
    check("post-reset 0x55 valid", OUT_DATA_VALID, 1'b1);
    check("post-reset 0x55 overrun", OUT_OVERRUN, 1'b0);

    // Randomised waveform against the reference model.
    buildRandom();
    @(negedge CLK);
    RESET = 1'b1;
    IN_SERIAL_RX = 1'b1;
    IN_READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge CLK);
      if (i > 0)
        check($sformatf("rand edge %0d", i - 1),
              {OUT_DATA_VALID, OUT_OVERRUN, OUT_FRAME_ERROR, OUT_DATA}, expVec[i - 1]);
      IN_SERIAL_RX = lineArr[i];
      IN_READ = rdArr[i];
    end
    @(negedge CLK);
    check($sformatf("rand edge %0d", N - 1),
          {OUT_DATA_VALID, OUT_OVERRUN, OUT_FRAME_ERROR, OUT_DATA}, expVec[N - 1]);
    IN_READ = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
